imem_fetch_unit: RTL and testbench
==================================

# imem_fetch_unit

Instruction-fetch front end driving the read-only port (port 1) of the 32x512 instruction SRAM. Generates sequential word addresses from a PC, issues one read per cycle, captures the SRAM's one-cycle-latency read data into a small prefetch FIFO, and presents instructions to the decode stage over a valid/ready handshake. Supports redirect (branch/jump) with flush of buffered and in-flight fetches.

## Interface
- ADDR_WIDTH, 9, SRAM word-address width (512 words)
- DATA_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, byte PC loaded on reset
- FIFO_DEPTH, 2, prefetch entries (power of two, ≥2)

- clk  in  1  single clock; same net as SRAM clk1
- rst  in  1  synchronous, active-high reset
- fetch_en  in  1  allow new SRAM reads when high
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  32  new byte PC; bits [1:0] ignored
- mem_csb1  out  1  SRAM port-1 chip select, active low
- mem_addr1  out  ADDR_WIDTH  SRAM port-1 word address
- mem_dout1  in  DATA_WIDTH  SRAM port-1 read data
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts head
- inst_data  out  DATA_WIDTH  instruction at head
- inst_pc  out  32  byte PC of inst_data

## Operation
- FSM states: IDLE (no issue), RUN (issue when credit available). rst → IDLE; IDLE→RUN when fetch_en=1; RUN→IDLE when fetch_en=0 (in-flight read still captured).
- Issue in RUN when count + inflight − pop < FIFO_DEPTH, where pop = inst_valid & inst_ready. Issue drives mem_csb1=0, mem_addr1=fetch_pc[ADDR_WIDTH+1:2]; fetch_pc += 4 at that edge.
- Address wraps modulo 2^(ADDR_WIDTH+2) bytes; inst_pc keeps full 32-bit PC.
- inflight flag set on issue, cleared next cycle; in that cycle mem_dout1 and the issued PC are written to FIFO tail.
- redirect_valid: fetch_pc ← {redirect_pc[31:2],2'b00}; FIFO emptied; any in-flight response discarded (kill bit); issue in the same cycle is suppressed. Issue at redirect_pc begins next cycle if RUN.
- redirect_valid concurrent with pop: handshake counts as completed, then flush.
- redirect_valid in IDLE: PC updated, no issue.
- Full FIFO with inst_ready=0: no issue, head held stable (inst_data, inst_pc unchanged until accepted).

## Timing
- Reset values: mem_csb1=1, mem_addr1=0, inst_valid=0, inst_data=0, inst_pc=RESET_PC, FIFO count 0, inflight 0, state IDLE.
- Read latency: issue in cycle t (sampled by SRAM at end of t) → mem_dout1 sampled at end of t+1 → inst_valid in cycle t+2. mem_dout1 is never sampled in any other cycle (SRAM drives X after hold).
- First issue: cycle after rst deasserts with fetch_en=1 (IDLE→RUN), i.e. first inst_valid three cycles after rst low.
- Sustained throughput 1 instr/cycle with inst_ready held high and FIFO_DEPTH=2.
- Redirect in cycle r → first valid redirected instruction in cycle r+3.
- rst mid-operation overrides redirect and discards in-flight data.

## Structure
- Shared package imem_pkg: ADDR_WIDTH/DATA_WIDTH constants, RESET_PC, fetch FSM state enum, FIFO entry typedef {pc[31:0], data[DATA_WIDTH-1:0]}.
- One sub-module: imem_prefetch_fifo (synchronous FIFO, push/pop/flush, count output, same clk/rst).

## Test plan
- Reset, fetch_en=1, inst_ready=1, SRAM preloaded mem[i]=i → inst_valid first at cycle 3; inst_pc 0,4,8,… with inst_data 0,1,2,… one per cycle, no gaps.
- inst_ready=0 for 10 cycles mid-stream → exactly 2 entries buffered, mem_csb1=1 while full, head (pc 0x10, data 4) stable; release → stream resumes at 0x14 with no loss/duplication.
- redirect_valid pc=0x0000_0103 during stream → buffered/in-flight words dropped, next inst_pc=0x100, data=mem[0x40], 3 cycles after redirect.
- Redirect coinciding with handshake of pc 0x8 → 0x8 counted once, no stale 0xC/0x10 delivered afterwards.
- Fetch from pc 0x7FC → next inst_pc 0x800, mem_addr1 wraps to 0, data=mem[0].
- rst asserted with read in flight and FIFO full → next cycle all outputs at reset values; restart from RESET_PC.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Fetch FSM states, prefetch FIFO entry layout, default geometry.
package imem_pkg;

    localparam int ADDR_WIDTH = 9;
    localparam int DATA_WIDTH = 32;
    localparam int FIFO_DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic {
        IDLE,
        RUN
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]           pc;
        logic [DATA_WIDTH-1:0] data;
    } fifo_entry_t;

    function automatic logic [31:0] word_to_pc(
        input logic [29:0] word
    );
        return {word, 2'b00};
    endfunction

endpackage

// File: rtl/imem_prefetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instruction} pairs.
// Flush drops all entries; storage resets so the head reads INIT_PC/0.
module imem_prefetch_fifo
    import imem_pkg::*;
#(
    parameter int          DEPTH   = 2,
    parameter logic [31:0] INIT_PC = 32'h0,
    localparam int         PW      = $clog2(DEPTH),
    localparam int         CW      = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fifo_entry_t   wr_entry,
    output fifo_entry_t   head,
    output logic [CW-1:0] count
);

    fifo_entry_t   slots [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '{pc: INIT_PC, data: '0};
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= wr_entry;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = slots[rd_ptr];

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction-fetch front end for SRAM port 1: PC sequencing, one read
// per cycle under FIFO credit, capture into prefetch FIFO, redirect flush.
module imem_fetch_unit #(
    parameter int          ADDR_WIDTH = imem_pkg::ADDR_WIDTH,
    parameter int          DATA_WIDTH = imem_pkg::DATA_WIDTH,
    parameter logic [31:0] RESET_PC   = imem_pkg::RESET_PC,
    parameter int          FIFO_DEPTH = imem_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  mem_csb1,
    output logic [ADDR_WIDTH-1:0] mem_addr1,
    input  logic [DATA_WIDTH-1:0] mem_dout1,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [31:0]           inst_pc
);

    import imem_pkg::fetch_state_e;
    import imem_pkg::fifo_entry_t;
    import imem_pkg::IDLE;
    import imem_pkg::RUN;
    import imem_pkg::word_to_pc;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   issued_pc;
    logic          inflight;
    logic          issue;
    logic          pop;
    logic          push;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    fifo_entry_t   head;
    fifo_entry_t   wr_entry;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Credit: entries held plus the read in flight, less this cycle's pop.
    assign pop   = inst_valid & inst_ready;
    assign occ   = {1'b0, count}
                 + (CW+1)'(inflight)
                 - (CW+1)'(pop);
    assign issue = (state == RUN)
                 & fetch_en
                 & ~redirect_valid
                 & (occ < (CW+1)'(FIFO_DEPTH));

    assign mem_csb1  = ~issue;
    assign mem_addr1 = fetch_pc[ADDR_WIDTH+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            issued_pc <= RESET_PC;
            inflight  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (fetch_en) state <= RUN;
                RUN:  if (!fetch_en) state <= IDLE;
            endcase
            inflight <= issue;
            if (issue) begin
                issued_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= word_to_pc(redirect_pc[31:2]);
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // A response landing during a redirect belongs to the old stream.
    assign push     = inflight & ~redirect_valid;
    assign wr_entry = '{pc: issued_pc, data: mem_dout1};

    imem_prefetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .INIT_PC (RESET_PC)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count)
    );

    assign inst_valid = (count != '0);
    assign inst_data  = head.data;
    assign inst_pc    = head.pc;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit with a 512-word SRAM model
// preloaded mem[i]=i; table-driven stream plus hand-written sequences.
module tb_imem_fetch_unit;

    logic        clk            = 1'b0;
    logic        rst            = 1'b1;
    logic        fetch_en       = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        inst_ready     = 1'b0;
    logic        mem_csb1;
    logic [8:0]  mem_addr1;
    logic [31:0] mem_dout1;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    logic [31:0] sram [512];
    int          total  = 0;
    int          passed = 0;

    typedef struct {
        logic        rst;
        logic        fen;
        logic        rdy;
        logic        csb;
        logic [8:0]  addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];

    imem_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_csb1       (mem_csb1),
        .mem_addr1      (mem_addr1),
        .mem_dout1      (mem_dout1),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    // SRAM port 1: one-cycle latency, garbage when not read last cycle.
    always @(posedge clk) begin
        if (!mem_csb1) mem_dout1 <= sram[mem_addr1];
        else           mem_dout1 <= 32'hDEAD_BEEF;
    end

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    task automatic expect_out(input string n, input logic csb,
                              input logic [8:0] addr, input logic v,
                              input logic [31:0] pc, input logic [31:0] d,
                              input logic hd);
        check({n, "_csb"},   32'(mem_csb1),   32'(csb));
        check({n, "_addr"},  32'(mem_addr1),  32'(addr));
        check({n, "_valid"}, 32'(inst_valid), 32'(v));
        if (hd) begin
            check({n, "_pc"},   inst_pc,   pc);
            check({n, "_data"}, inst_data, d);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input string n, input logic rv,
                       input logic [31:0] rpc, input logic rdy,
                       input logic csb, input logic [8:0] addr,
                       input logic v, input logic [31:0] pc,
                       input logic [31:0] d);
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        #1;
        expect_out(n, csb, addr, v, pc, d, v);
        step();
    endtask

    function automatic vec_t mk(input logic r, input logic f,
                                input logic rd, input logic c,
                                input logic [8:0] a, input logic v,
                                input logic [31:0] p,
                                input logic [31:0] d);
        vec_t t;
        t = '{r, f, rd, c, a, v, p, d};
        return t;
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) sram[i] = 32'(i);

        // Reset, start, first valid three cycles after rst low.
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2, 1, 0, 0));
        for (int k = 1; k <= 3; k++)
            vecs.push_back(mk(0, 1, 1, 0, 9'(k + 2), 1, 32'(4 * k), 32'(k)));
        // Decode stalls ten cycles: FIFO fills, issue stops, head holds.
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(0, 1, 0, 1, 6, 1, 32'h10, 4));
        vecs.push_back(mk(0, 1, 1, 0, 6, 1, 32'h10, 4));
        for (int k = 5; k <= 7; k++)
            vecs.push_back(mk(0, 1, 1, 0, 9'(k + 2), 1, 32'(4 * k), 32'(k)));

        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst            = vecs[i].rst;
            fetch_en       = vecs[i].fen;
            inst_ready     = vecs[i].rdy;
            redirect_valid = 1'b0;
            #1;
            expect_out($sformatf("v%0d", i), vecs[i].csb, vecs[i].addr,
                       vecs[i].valid, vecs[i].pc, vecs[i].data, 1'b1);
            step();
        end

        // Redirect to unaligned 0x103 mid-stream.
        cyc("rd_r0", 1, 32'h103, 1, 1, 9'h0A, 1, 32'h20, 32'd8);
        cyc("rd_r1", 0, 32'h0,   1, 0, 9'h40, 0, 32'h0, 32'h0);
        cyc("rd_r2", 0, 32'h0,   1, 0, 9'h41, 0, 32'h0, 32'h0);
        cyc("rd_r3", 0, 32'h0,   1, 0, 9'h42, 1, 32'h100, 32'h40);
        cyc("rd_r4", 0, 32'h0,   1, 0, 9'h43, 1, 32'h104, 32'h41);

        // Redirect back to 0 while popping 0x108.
        cyc("rz_q0", 1, 32'h0, 1, 1, 9'h44, 1, 32'h108, 32'h42);
        cyc("rz_q1", 0, 32'h0, 1, 0, 9'h00, 0, 32'h0, 32'h0);
        cyc("rz_q2", 0, 32'h0, 1, 0, 9'h01, 0, 32'h0, 32'h0);
        cyc("rz_q3", 0, 32'h0, 1, 0, 9'h02, 1, 32'h0, 32'h0);
        cyc("rz_q4", 0, 32'h0, 1, 0, 9'h03, 1, 32'h4, 32'h1);

        // Redirect coincides with handshake of 0x8; then wrap past 0x7FC.
        cyc("hs_s0", 1, 32'h7F8, 1, 1, 9'h04,  1, 32'h8, 32'h2);
        cyc("hs_s1", 0, 32'h0,   1, 0, 9'h1FE, 0, 32'h0, 32'h0);
        cyc("hs_s2", 0, 32'h0,   1, 0, 9'h1FF, 0, 32'h0, 32'h0);
        cyc("wr_s3", 0, 32'h0,   1, 0, 9'h000, 1, 32'h7F8, 32'h1FE);
        cyc("wr_s4", 0, 32'h0,   1, 0, 9'h001, 1, 32'h7FC, 32'h1FF);
        cyc("wr_s5", 0, 32'h0,   1, 0, 9'h002, 1, 32'h800, 32'h0);
        cyc("wr_s6", 0, 32'h0,   1, 0, 9'h003, 1, 32'h804, 32'h1);

        // Reset with a read in flight, stalled decode and a redirect.
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        inst_ready     = 1'b0;
        #1;
        step();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        #1;
        expect_out("rs_c0", 1, 9'h0, 0, 32'h0, 32'h0, 1'b1);
        step();
        expect_out("rs_c1", 0, 9'h0, 0, 32'h0, 32'h0, 1'b1);
        step();
        cyc("rs_c2", 0, 32'h0, 1, 0, 9'h1, 0, 32'h0, 32'h0);
        cyc("rs_c3", 0, 32'h0, 1, 0, 9'h2, 1, 32'h0, 32'h0);
        cyc("rs_c4", 0, 32'h0, 1, 0, 9'h3, 1, 32'h4, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
